trap_controller: RTL and testbench

TRAP_CONTROLLER -- requirements
Module: trap_controller

---
 rtl/trap_controller.sv | 77 +++++++
 tb/tb_trap_controller.sv | 116 +++++++++++
 2 files changed

// File: rtl/trap_controller.sv
// trap_controller: sequences trap entry/return CSR traffic and issues the flush/redirect strobe
module trap_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  trap_status,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        csr_ready,
  input  logic [31:0] csr_read_data,
  output logic        trap_done,
  output logic        standby_mode,
  output logic        pth_done_flush,
  output logic [31:0] trap_target,
  output logic        csr_trap_write_enable,
  output logic [11:0] csr_trap_address,
  output logic [31:0] csr_trap_write_data
);
  typedef enum logic [2:0] {IDLE, STANDBY, WR_MEPC, WR_MCAUSE, WR_MTVAL, RD_MTVEC, RD_MEPC, FLUSH} state_t;
  state_t state, state_n;
  logic [1:0] cnt;
  logic [31:0] cap_pc, cap_tval;
  logic [3:0] cap_cause, cause_n;
  logic cap_mret, take, sync_trap, rd_state;
  assign take = state == IDLE && trap_status != 3'd0 && trap_status != 3'd7;
  assign sync_trap = trap_status == 3'd1 || trap_status == 3'd2;
  assign rd_state = state == RD_MTVEC || state == RD_MEPC;
  assign cause_n = trap_status == 3'd1 ? 4'd11 : trap_status == 3'd2 ? 4'd3 :
                   trap_status == 3'd4 ? 4'd4 : trap_status == 3'd5 ? 4'd6 : 4'd0;
  // state register
  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else state <= state_n;
  // capture of trap context, standby counter and redirect target
  always_ff @(posedge clk)
    if (!reset) begin
      cnt <= 2'd0;
      cap_pc <= 32'd0;
      cap_tval <= 32'd0;
      cap_cause <= 4'd0;
      cap_mret <= 1'b0;
      trap_target <= 32'd0;
    end else begin
      cnt <= state == STANDBY ? cnt + 2'd1 : 2'd0;
      if (take) begin
        cap_pc <= trap_pc;
        cap_tval <= sync_trap ? 32'd0 : trap_tval;
        cap_cause <= cause_n;
        cap_mret <= trap_status == 3'd6;
      end
      if (rd_state && csr_ready) trap_target <= {csr_read_data[31:2], 2'b00};
    end
  // next-state and Moore outputs
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (take) state_n = (sync_trap || trap_status == 3'd6) ? STANDBY : WR_MEPC;
      STANDBY:   if (cnt == 2'd1) state_n = cap_mret ? RD_MEPC : WR_MEPC;
      WR_MEPC:   if (csr_ready) state_n = WR_MCAUSE;
      WR_MCAUSE: if (csr_ready) state_n = WR_MTVAL;
      WR_MTVAL:  if (csr_ready) state_n = RD_MTVEC;
      RD_MTVEC:  if (csr_ready) state_n = FLUSH;
      RD_MEPC:   if (csr_ready) state_n = FLUSH;
      default:   state_n = IDLE;
    endcase
    csr_trap_write_enable = state == WR_MEPC || state == WR_MCAUSE || state == WR_MTVAL;
    trap_done = !(csr_trap_write_enable || rd_state);
    standby_mode = state == STANDBY;
    pth_done_flush = state == FLUSH;
    csr_trap_address = state == WR_MEPC || state == RD_MEPC ? 12'h341 :
                       state == WR_MCAUSE ? 12'h342 :
                       state == WR_MTVAL ? 12'h343 :
                       state == RD_MTVEC ? 12'h305 : 12'h000;
    csr_trap_write_data = state == WR_MEPC ? cap_pc :
                          state == WR_MCAUSE ? {28'd0, cap_cause} :
                          state == WR_MTVAL ? cap_tval : 32'd0;
  end
endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: directed scoreboard bench for trap_controller
module tb_trap_controller;
  logic clk = 0, reset = 0, csr_ready = 1;
  logic [2:0] trap_status = 0;
  logic [31:0] trap_pc = 0, trap_tval = 0, csr_read_data = 0;
  logic trap_done, standby_mode, pth_done_flush, csr_trap_write_enable;
  logic [31:0] trap_target, csr_trap_write_data;
  logic [11:0] csr_trap_address;
  typedef struct {logic [11:0] a; logic [31:0] d;} wr_t;
  wr_t q[$];
  int tests = 0, fails = 0;

  trap_controller dut (
    .clk(clk), .reset(reset), .trap_status(trap_status), .trap_pc(trap_pc), .trap_tval(trap_tval),
    .csr_ready(csr_ready), .csr_read_data(csr_read_data), .trap_done(trap_done),
    .standby_mode(standby_mode), .pth_done_flush(pth_done_flush), .trap_target(trap_target),
    .csr_trap_write_enable(csr_trap_write_enable), .csr_trap_address(csr_trap_address),
    .csr_trap_write_data(csr_trap_write_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] cause(input logic [2:0] s);
    return s == 3'd1 ? 32'd11 : s == 3'd2 ? 32'd3 : s == 3'd4 ? 32'd4 : s == 3'd5 ? 32'd6 : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one trap at the current (IDLE) negedge; ends at the negedge of the IDLE cycle after FLUSH.
  task automatic run_trap(input logic [2:0] st, input logic [31:0] pc, input logic [31:0] tval,
                          input logic [31:0] rd, input int lat, input int sb, input int stall, input bit chain);
    int nsb = 0;
    int sl = stall;
    bit done = 0;
    wr_t w;
    trap_status = st; trap_pc = pc; trap_tval = tval; csr_read_data = rd; csr_ready = 1;
    if (st != 3'd6) begin
      q.push_back('{12'h341, pc});
      q.push_back('{12'h342, cause(st)});
      q.push_back('{12'h343, (st == 3'd1 || st == 3'd2) ? 32'd0 : tval});
    end
    @(posedge clk); #1 trap_status = 0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      if (standby_mode) nsb++;
      if (csr_trap_write_enable && csr_trap_address == 12'h342 && sl > 0) begin
        csr_ready = 0;
        sl--;
        check("stall_addr", {20'd0, csr_trap_address}, 32'h342);
        check("stall_data", csr_trap_write_data, cause(st));
        check("stall_done", {31'd0, trap_done}, 32'd0);
      end else csr_ready = 1;
      if (csr_trap_write_enable && csr_ready) begin
        check("wr_pending", q.size(), q.size() > 0 ? q.size() : 1);
        if (q.size() > 0) begin
          w = q.pop_front();
          check("wr_addr", {20'd0, csr_trap_address}, {20'd0, w.a});
          check("wr_data", csr_trap_write_data, w.d);
        end
      end
      if (pth_done_flush) begin
        done = 1;
        check("flush_latency", c, lat);
        check("flush_target", trap_target, {rd[31:2], 2'b00});
        check("standby_cycles", nsb, sb);
        check("writes_left", q.size(), 0);
        if (chain) trap_status = 3'd2;
        @(posedge clk); #1 trap_status = 0;
        @(negedge clk);
        check("post_flush_idle", {29'd0, trap_done, standby_mode, pth_done_flush}, 32'b100);
      end
    end
    if (!done) check("timeout", {31'd0, done}, 32'd1);
    q.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_flags", {28'd0, trap_done, standby_mode, pth_done_flush, csr_trap_write_enable}, 32'b1000);
    check("rst_addr", {20'd0, csr_trap_address}, 0);
    check("rst_target", trap_target, 0);
    reset = 1;
    @(negedge clk);
    trap_status = 3'd7;
    @(posedge clk); #1 trap_status = 0;
    @(negedge clk);
    check("st7_ignored", {30'd0, trap_done, standby_mode}, 32'b10);
    run_trap(3'd1, 32'h100, 32'hdead, 32'h2003, 7, 2, 0, 0);
    run_trap(3'd4, 32'h200, 32'h1001, 32'h2003, 5, 0, 0, 0);
    run_trap(3'd6, 32'h0, 32'h0, 32'h104, 4, 2, 0, 0);
    run_trap(3'd5, 32'h210, 32'h2002, 32'h3001, 8, 0, 3, 1);
    run_trap(3'd1, 32'h500, 32'h0, 32'h4000, 7, 2, 0, 0);
    run_trap(3'd3, 32'h602, 32'h602, 32'h5002, 5, 0, 0, 0);
    trap_status = 3'd3; trap_pc = 32'h300; trap_tval = 32'h302;
    @(posedge clk); #1 trap_status = 0;
    repeat (3) @(negedge clk);
    check("mtval_addr", {20'd0, csr_trap_address}, 32'h343);
    reset = 0;
    @(posedge clk); #1 reset = 1;
    @(negedge clk);
    check("abort_flags", {28'd0, trap_done, standby_mode, pth_done_flush, csr_trap_write_enable}, 32'b1000);
    check("abort_addr", {20'd0, csr_trap_address}, 0);
    check("abort_data", csr_trap_write_data, 0);
    check("abort_target", trap_target, 0);
    run_trap(3'd2, 32'h400, 32'h55, 32'h8000, 7, 2, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
